// File: rtl/ucode_seq_pkg.sv
// rtl/ucode_seq_pkg.sv - shared constants for the microcode sequencer
// Purpose: ROM class encodings and the sequencer FSM state type.
package ucode_seq_pkg;

   // ROM class select, as decoded externally from the instruction word
   localparam logic [1:0] CLS_NONE = 2'b00;
   localparam logic [1:0] CLS_AR   = 2'b01;
   localparam logic [1:0] CLS_IMM  = 2'b10;
   localparam logic [1:0] CLS_MEM  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

endpackage

// File: rtl/ucode_seq.sv
// rtl/ucode_seq.sv - two-state microcode sequencer driving a class-selected micro-op ROM
// Purpose: accepts an instruction, walks micro-op steps {opcode, step} through the
//          selected ROM until the ROM flags the last micro-op or the step counter
//          runs out, then reports done / overrun; en==00 is rejected as illegal.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   instr, instr_valid     offered instruction word and its valid flag
//   en                     ROM class select for the offered instruction
//   rom_last               last-micro-op flag from the ROM word being read
//   stall                  datapath hold request
//   instr_ready            high when idle and able to accept
//   rom_rd, rom_sel,       micro-op read strobe, latched class and
//   rom_addr               {opcode field, step} address
//   busy                   high while executing
//   done, illegal, overrun single-cycle completion status pulses
module ucode_seq #(
   parameter int STEP_W = 3,
   parameter int OPF_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                instr,
   input  logic                      instr_valid,
   input  logic [1:0]                en,
   input  logic                      rom_last,
   input  logic                      stall,
   output logic                      instr_ready,
   output logic                      rom_rd,
   output logic [1:0]                rom_sel,
   output logic [OPF_W+STEP_W-1:0]   rom_addr,
   output logic                      busy,
   output logic                      done,
   output logic                      illegal,
   output logic                      overrun
);
   import ucode_seq_pkg::*;

   localparam logic [STEP_W-1:0] STEP_MAX = '1;
   localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

   state_t             state_q;
   logic [STEP_W-1:0]  step_q;
   logic [STEP_W-1:0]  step_d;
   logic [OPF_W-1:0]   opc_q;
   logic [1:0]         sel_q;
   logic               done_q;
   logic               illegal_q;
   logic               overrun_q;

   // Upper instruction bits carry no meaning for ROM addressing
   generate
      if (OPF_W < 8) begin : g_unused_hi
         logic unused_instr_hi;
         assign unused_instr_hi = ^instr[7:OPF_W];
      end
   endgenerate

   assign step_d = step_q + STEP_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         step_q    <= '0;
         opc_q     <= '0;
         sel_q     <= CLS_NONE;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         overrun_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (instr_valid) begin
                  if (en == CLS_NONE) begin
                     // Rejected: address/class outputs keep their previous values
                     illegal_q <= 1'b1;
                  end else begin
                     state_q <= ST_EXEC;
                     opc_q   <= instr[OPF_W-1:0];
                     sel_q   <= en;
                     step_q  <= '0;
                  end
               end
            end
            ST_EXEC: begin
               if (!stall) begin
                  // rom_last wins over exhaustion on the final step
                  if (rom_last) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end else if (step_q == STEP_MAX) begin
                     state_q   <= ST_IDLE;
                     overrun_q <= 1'b1;
                  end else begin
                     step_q <= step_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy        = (state_q == ST_EXEC);
   assign instr_ready = (state_q == ST_IDLE);
   assign rom_rd      = busy && !stall;
   assign rom_sel     = sel_q;
   assign rom_addr    = {opc_q, step_q};
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_ucode_seq.sv
// tb/tb_ucode_seq.sv - scoreboard bench for the microcode sequencer
module tb_ucode_seq;

   localparam int EV_DONE = 1;
   localparam int EV_ILL  = 2;
   localparam int EV_OVR  = 3;

   typedef struct {
      int         cyc;
      logic [6:0] addr;
      logic [1:0] sel;
   } rd_t;

   typedef struct {
      int cyc;
      int kind;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] instr;
   logic       instr_valid;
   logic [1:0] en;
   logic       rom_last;
   logic       stall;
   logic       instr_ready;
   logic       rom_rd;
   logic [1:0] rom_sel;
   logic [6:0] rom_addr;
   logic       busy;
   logic       done;
   logic       illegal;
   logic       overrun;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   rd_t rdq[$];
   ev_t evq[$];

   ucode_seq #(.STEP_W(3), .OPF_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr       (instr),
      .instr_valid (instr_valid),
      .en          (en),
      .rom_last    (rom_last),
      .stall       (stall),
      .instr_ready (instr_ready),
      .rom_rd      (rom_rd),
      .rom_sel     (rom_sel),
      .rom_addr    (rom_addr),
      .busy        (busy),
      .done        (done),
      .illegal     (illegal),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rom_rd"},      {31'd0, rom_rd},      32'd0);
      chk({tag, "_busy"},        {31'd0, busy},        32'd0);
      chk({tag, "_instr_ready"}, {31'd0, instr_ready}, 32'd1);
      chk({tag, "_rom_sel"},     {30'd0, rom_sel},     32'd0);
      chk({tag, "_rom_addr"},    {25'd0, rom_addr},    32'd0);
      chk({tag, "_status"},      {29'd0, done, illegal, overrun}, 32'd0);
   endtask

   // Monitor: every read strobe and every status pulse must match the next expectation
   always @(negedge clk) begin
      if (rst_n) begin
         if (rom_rd) begin
            if (rdq.size() == 0) begin
               chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
               rd_t r;
               r = rdq.pop_front();
               chk("rd_cycle", cyc, r.cyc);
               chk("rd_addr", {25'd0, rom_addr}, {25'd0, r.addr});
               chk("rd_sel", {30'd0, rom_sel}, {30'd0, r.sel});
            end
         end
         if ((int'(done) + int'(illegal) + int'(overrun)) > 1) begin
            chk("status_exclusive", {29'd0, done, illegal, overrun}, 32'd0);
         end else if (done || illegal || overrun) begin
            int k;
            k = done ? EV_DONE : (illegal ? EV_ILL : EV_OVR);
            if (evq.size() == 0) begin
               chk("event_unexpected", k, 0);
            end else begin
               ev_t e;
               e = evq.pop_front();
               chk("event_cycle", cyc, e.cyc);
               chk("event_kind", k, e.kind);
            end
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         instr_valid = 1'b0;
         instr       = 8'($urandom);
         en          = 2'($urandom);
         stall       = 1'($urandom);
         rom_last    = 1'($urandom);
         next_cycle();
      end
   endtask

   // Offer one instruction in the current (idle) cycle. k = micro-op index (1-based) on
   // which rom_last is returned; k>8 never returns it. smask bit i stalls EXEC cycle i.
   // abort drops reset when step 2 is first presented.
   task automatic offer(input logic [7:0] ins, input logic [1:0] e, input int k,
                        input logic [15:0] smask, input bit abort);
      int  r;
      int  i;
      bit  ended;
      bit  s;
      logic [2:0] rs;
      logic [3:0] opc;
      opc = ins[3:0];
      chk("ready_when_idle", {31'd0, instr_ready}, 32'd1);
      instr       = ins;
      en          = e;
      instr_valid = 1'b1;
      stall       = 1'($urandom);
      rom_last    = 1'($urandom);
      if (e == 2'b00) begin
         evq.push_back('{cyc: cyc + 1, kind: EV_ILL});
         next_cycle();
         return;
      end
      next_cycle();
      r = 0;
      i = 0;
      ended = 1'b0;
      while (!ended) begin
         instr_valid = 1'($urandom);
         instr       = 8'($urandom);
         en          = 2'($urandom);
         if (abort && r == 2) begin
            rst_n = 1'b0;
            stall = 1'b0;
            rom_last = 1'b0;
            instr_valid = 1'b0;
            #1;
            chk_reset_outputs("abort");
            next_cycle();
            next_cycle();
            rst_n = 1'b1;
            return;
         end
         s = (i < 16) ? smask[i] : 1'b0;
         stall = s;
         chk("busy_exec", {30'd0, busy, instr_ready}, 32'd2);
         if (!s) begin
            rs = r[2:0];
            rdq.push_back('{cyc: cyc, addr: {opc, rs}, sel: e});
            rom_last = (r == k - 1);
            r = r + 1;
            if (r == k) begin
               evq.push_back('{cyc: cyc + 1, kind: EV_DONE});
               ended = 1'b1;
            end else if (r == 8) begin
               evq.push_back('{cyc: cyc + 1, kind: EV_OVR});
               ended = 1'b1;
            end
         end else begin
            rom_last = 1'($urandom);
         end
         i = i + 1;
         next_cycle();
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      instr       = 8'h00;
      instr_valid = 1'b1;
      en          = 2'b01;
      stall       = 1'b0;
      rom_last    = 1'b0;
      #1;
      chk_reset_outputs("reset_async");
      next_cycle();
      next_cycle();
      chk_reset_outputs("reset_held");
      rst_n = 1'b1;
      idle(1);

      // Three-step AR instruction, addresses 0x18..0x1A, done at N+4
      offer(8'h03, 2'b01, 3, 16'h0000, 1'b0);
      // Illegal class, immediately followed by a legal instruction
      offer(8'h50, 2'b00, 1, 16'h0000, 1'b0);
      // IMM with stall in EXEC cycles 2 and 3
      offer(8'h27, 2'b10, 4, 16'h0006, 1'b0);
      // MEM with rom_last never set: eight reads then overrun
      offer(8'h0B, 2'b11, 9, 16'h0000, 1'b0);
      // rom_last on the very last step must win over exhaustion
      offer(8'h0C, 2'b01, 8, 16'h0000, 1'b0);
      // Back-to-back pair, second offered in the done cycle
      offer(8'h01, 2'b01, 1, 16'h0000, 1'b0);
      offer(8'h0F, 2'b10, 2, 16'h0000, 1'b0);
      idle(2);
      // Reset mid-instruction at step 2
      offer(8'h05, 2'b01, 5, 16'h0000, 1'b1);
      idle(3);
      chk("abort_no_event", evq.size() + rdq.size(), 0);

      for (int n = 0; n < 60; n++) begin
         logic [1:0]  e;
         logic [15:0] m;
         e = ($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         m = 16'($urandom & $urandom);
         offer(8'($urandom), e, $urandom_range(1, 9), m, ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      idle(4);
      chk("rd_queue_drained", rdq.size(), 0);
      chk("event_queue_drained", evq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
